bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
//  Front-end stage for bcd_adder: turns binary operands into packed BCD digits that feed its a/b inputs.
//  Uses a start/busy/done handshake. The result is held stable until the next accepted conversion.
// PARAMETERS
//  BIN_W   8  width of binary input; also number of shift cycles per conversion
//  DIGITS  3  BCD digits produced; must satisfy 10**DIGITS > 2**BIN_W - 1 (checked in elaboration)
// PORTS
//  clk      in   1           rising-edge clock
//  rst_n    in   1           synchronous reset, active low
//  start    in   1           request conversion of bin_in; sampled only when idle or done
//  bin_in   in   BIN_W       binary operand, captured on the accepting edge only
//  busy     out  1           conversion in progress
//  done     out  1           one-cycle pulse: bcd_out updated this cycle
//  bcd_out  out  4*DIGITS    packed BCD, digit 0 in [3:0], registered
//  neg      out  1           sign of result (only when BIN2BCD_SIGNED_EN defined)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, bcd_out=0, neg=0.
//    Reset wins over everything, including mid-conversion; the partial result is discarded.
//  - FSM states: IDLE, SHIFT, DONE.
//    - IDLE --start--> SHIFT: load bin_in into the shift register; clear the BCD scratch and bit counter; busy=1.
//    - SHIFT: each edge, first add 3 to every scratch digit >=5, then shift {scratch,bin} left by 1; counter++.
//    - After the BIN_W-th shift: SHIFT -> DONE. bcd_out <= scratch, busy=0, done=1.
//    - DONE --start--> SHIFT: back-to-back acceptance; done drops and busy rises.
//    - DONE --!start--> IDLE: done=0.
//  - Latency: start accepted at edge E0; done=1 and bcd_out valid in the cycle after edge E(BIN_W).
//    Throughput is one conversion per BIN_W+1 cycles.
//  - start while busy=1 is ignored (not queued). bin_in may change freely after the accepting edge.
//  - bcd_out keeps its previous result during a conversion; it changes only on the edge that raises done.
//  - Each digit is always 0..9. Input 2**BIN_W-1 must not overflow DIGITS digits.
//  - The add-3 correction applies to all DIGITS digits in parallel within one cycle (combinational per digit).
//  - The counter is $clog2(BIN_W+1) bits wide. It never wraps within a conversion.
// CONFIGURATION
//  BIN2BCD_SIGNED_EN
//  - Defined: bin_in is two's complement.
//    - On accept, neg <= bin_in[BIN_W-1] and the magnitude |bin_in| is loaded.
//    - The most-negative input converts to 2**(BIN_W-1) (e.g. -128 -> 0x128, neg=1).
//    - neg updates with bcd_out, on the done edge. Latency is unchanged.
//  - Undefined: bin_in is unsigned, the neg port is absent, and behaviour is as above.
// TESTING
//  1. rst_n=0 for 2 clks, then rst_n=1 -> busy=0, done=0, bcd_out=12'h000.
//  2. start=1 for 1 clk with bin_in=8'd255 -> busy high for 8 cycles; done pulses 1 cycle;
//     bcd_out=12'h255 held until the next start.
//  3. Directed values 0, 9, 10, 99, 100, 128 -> bcd_out 12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128.
//  4. start pulsed again 3 cycles into a conversion of 8'd42 with bin_in=8'd7
//     -> ignored; result 12'h042; exactly one done pulse.
//  5. rst_n=0 for 1 clk mid-conversion of 8'd200 -> busy=0, bcd_out=12'h000, no done pulse.
//     A new start with 8'd15 then yields 12'h015.
//  6. start held high continuously over inputs 8'd6 then 8'd9 -> two done pulses 9 cycles apart,
//     results 12'h006 then 12'h009. Feed the low digits into bcd_adder: sum=4'h5, c_out=1.
//     With BIN2BCD_SIGNED_EN, 8'h80 -> neg=1, bcd_out=12'h128.

Source files
------------

// File: rtl/bin_to_bcd_if.sv
// Start/busy/done handshake bundle for the sequential binary-to-BCD converter.
// The neg sign line exists only when BIN2BCD_SIGNED_EN is defined.
interface bin_to_bcd_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_SIGNED_EN
   logic                  neg;

   modport master (output start, bin_in, input busy, done, bcd_out, neg);
   modport slave  (input start, bin_in, output busy, done, bcd_out, neg);
`else
   modport master (output start, bin_in, input busy, done, bcd_out);
   modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit shifted into the BCD scratch per clock.
// Optional feature macro BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, sign on neg.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   bin_to_bcd_if.slave  bus
);
   // state | meaning
   // IDLE  | waiting for start, bcd_out holds last result
   // SHIFT | add-3 correction then shift, one bit per clock
   // DONE  | done=1 for one cycle, start here is accepted back-to-back
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;

   generate
      if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_check
         $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
      end
   endgenerate

   state_t           state, state_nx;
   logic [BIN_W-1:0] shreg, shreg_nx;
   logic [BW-1:0]    scratch, scratch_nx;
   logic [BW-1:0]    adj;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [BW-1:0]    bcd_q, bcd_nx;
   logic [BIN_W-1:0] load_val;

`ifdef BIN2BCD_SIGNED_EN
   logic sign_q, sign_nx;
   logic neg_q, neg_nx;

   // Negating the most-negative value wraps to itself, which read unsigned is 2**(BIN_W-1).
   assign load_val = bus.bin_in[BIN_W-1] ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;
   assign bus.neg  = neg_q;
`else
   assign load_val = bus.bin_in;
`endif

   always_comb begin
      adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      scratch_nx = scratch;
      cnt_nx     = cnt;
      bcd_nx     = bcd_q;
`ifdef BIN2BCD_SIGNED_EN
      sign_nx    = sign_q;
      neg_nx     = neg_q;
`endif
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_nx   = SHIFT;
               shreg_nx   = load_val;
               scratch_nx = '0;
               cnt_nx     = '0;
`ifdef BIN2BCD_SIGNED_EN
               sign_nx    = bus.bin_in[BIN_W-1];
`endif
            end else begin
               state_nx = IDLE;
            end
         end
         SHIFT: begin
            scratch_nx = {adj[BW-2:0], shreg[BIN_W-1]};
            shreg_nx   = {shreg[BIN_W-2:0], 1'b0};
            cnt_nx     = cnt + CW'(1);
            if (cnt == CW'(BIN_W - 1)) begin
               state_nx = DONE;
               bcd_nx   = {adj[BW-2:0], shreg[BIN_W-1]};
`ifdef BIN2BCD_SIGNED_EN
               neg_nx   = sign_q;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         scratch <= '0;
         cnt     <= '0;
         bcd_q   <= '0;
`ifdef BIN2BCD_SIGNED_EN
         sign_q  <= 1'b0;
         neg_q   <= 1'b0;
`endif
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         scratch <= scratch_nx;
         cnt     <= cnt_nx;
         bcd_q   <= bcd_nx;
`ifdef BIN2BCD_SIGNED_EN
         sign_q  <= sign_nx;
         neg_q   <= neg_nx;
`endif
      end
   end

   assign bus.busy    = (state == SHIFT);
   assign bus.done    = (state == DONE);
   assign bus.bcd_out = bcd_q;
endmodule
